// File: rtl/cpu_writeback.sv
// ---------------------------------------------------------------------------
// cpu_writeback
//
// Writer side of the register file. Merges main-pipeline results (p4) with
// results from the long-latency unit (mul/div) into the single p5 write port,
// tracks which registers still wait for a long-latency result, and tells
// decode (p2) when it must stall.
//
// Ports
//   clock, reset         system clock, synchronous active-high reset
//   p4_dest_reg/result   pipeline result; dest 0 = no write
//   lu_issue/issue_reg   long op issued this cycle, marks its dest pending
//   lu_valid/lu_ready    long-unit result handshake (see below)
//   lu_dest_reg/result   long-unit result payload
//   p2_reg_a/b, p2_literal_b, p2_dest_reg
//                        decode operands checked against the pending set
//   p2_hazard            decode must stall (combinational)
//   wb_stall             registered; pipeline must present p4_dest_reg=0
//                        in the cycle this is high
//   p5_dest_reg/result   regfile write port; dest 0 = no write
//
// Handshake: a long-unit result transfers on a rising clock edge where
// lu_valid && lu_ready are both high. lu_ready depends only on the current
// buffer occupancy (never on lu_valid), and the long unit must hold its
// payload stable while lu_valid is high and lu_ready is low. A transferred
// result with dest 0 is consumed and discarded.
//
// The result buffer is fall-through: a result arriving at an empty buffer
// while the pipeline slot is free goes straight to p5 on the same edge.
// ---------------------------------------------------------------------------
module cpu_writeback #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  p4_dest_reg,
    input  logic [31:0] p4_result,
    input  logic        lu_issue,
    input  logic [4:0]  lu_issue_reg,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_dest_reg,
    input  logic [31:0] lu_result,
    input  logic [4:0]  p2_reg_a,
    input  logic [4:0]  p2_reg_b,
    input  logic        p2_literal_b,
    input  logic [4:0]  p2_dest_reg,
    output logic        p2_hazard,
    output logic        wb_stall,
    output logic [4:0]  p5_dest_reg,
    output logic [31:0] p5_result
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    // Result buffer storage
    logic [4:0]       fifo_dest [FIFO_DEPTH];
    logic [31:0]      fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    // Starvation counter and pending scoreboard
    logic [STV_W-1:0] starve_cnt;
    logic [31:0]      pend;
    logic [31:0]      pend_next;

    // Set when p5 currently carries a long-unit result (drives pending clear)
    logic             p5_from_lu;

    // Per-cycle decisions
    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic p4_write;
    logic mem_pop;
    logic bypass;
    logic store;
    logic blocked;
    logic issue_live;
    logic use_b;

    always_comb begin
        fifo_empty = (count == '0);
        fifo_full  = (count == CNT_W'(FIFO_DEPTH));
        lu_ready   = !fifo_full;
        push       = lu_valid && !fifo_full && (lu_dest_reg != 5'd0);
        p4_write   = (p4_dest_reg != 5'd0);
        // Pipeline always wins the write port; the buffer drains otherwise.
        mem_pop    = !p4_write && !fifo_empty;
        bypass     = !p4_write && fifo_empty && push;
        store      = push && !bypass;
        // Only results already held in the buffer count as starving.
        blocked    = p4_write && !fifo_empty;
    end

    // Decode hazard: a register is unsafe while pending, and also in the
    // very cycle its long op issues (the pending bit is not set yet).
    always_comb begin
        issue_live = lu_issue && (lu_issue_reg != 5'd0);
        use_b      = !p2_literal_b;
        p2_hazard  = pend[p2_reg_a]
                   | (use_b & pend[p2_reg_b])
                   | pend[p2_dest_reg]
                   | (issue_live & ((lu_issue_reg == p2_reg_a)
                                  | (use_b & (lu_issue_reg == p2_reg_b))
                                  | (lu_issue_reg == p2_dest_reg)));
    end

    // Pending bit clears one cycle after p5 carries the long result, so a
    // regfile read in the write cycle (which returns old data) still stalls.
    // A set in the same cycle overrides the clear.
    always_comb begin
        pend_next = pend;
        if (p5_from_lu && (p5_dest_reg != 5'd0)) begin
            pend_next[p5_dest_reg] = 1'b0;
        end
        if (issue_live) begin
            pend_next[lu_issue_reg] = 1'b1;
        end
        pend_next[0] = 1'b0;
    end

    // Buffer storage has no reset; occupancy is governed by count.
    always_ff @(posedge clock) begin
        if (store) begin
            fifo_dest[wr_ptr] <= lu_dest_reg;
            fifo_data[wr_ptr] <= lu_result;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (mem_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(store) - CNT_W'(mem_pop);
        end
    end

    // Write-port select, registered into p5
    always_ff @(posedge clock) begin
        if (reset) begin
            p5_dest_reg <= 5'd0;
            p5_result   <= 32'd0;
            p5_from_lu  <= 1'b0;
        end else if (p4_write) begin
            p5_dest_reg <= p4_dest_reg;
            p5_result   <= p4_result;
            p5_from_lu  <= 1'b0;
        end else if (mem_pop) begin
            p5_dest_reg <= fifo_dest[rd_ptr];
            p5_result   <= fifo_data[rd_ptr];
            p5_from_lu  <= 1'b1;
        end else if (bypass) begin
            p5_dest_reg <= lu_dest_reg;
            p5_result   <= lu_result;
            p5_from_lu  <= 1'b1;
        end else begin
            p5_dest_reg <= 5'd0;
            p5_result   <= 32'd0;
            p5_from_lu  <= 1'b0;
        end
    end

    // Starvation: wb_stall rises for one cycle on the blocked cycle that
    // brings the count to STARVE_LIMIT; the pipeline then leaves its slot
    // empty and the buffer head pops, clearing the count. The counter
    // saturates so a misbehaving pipeline cannot wrap it.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
            wb_stall   <= 1'b0;
        end else begin
            wb_stall <= blocked && (starve_cnt == STV_W'(STARVE_LIMIT - 1));
            if (!blocked) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STV_W'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + STV_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend <= 32'd0;
        end else begin
            pend <= pend_next;
        end
    end

    // The pipeline must leave its slot empty while wb_stall is high.
    wb_stall_protocol : assert property (
        @(posedge clock) disable iff (reset) wb_stall |-> (p4_dest_reg == 5'd0)
    );

endmodule

// File: tb/tb_cpu_writeback.sv
// ---------------------------------------------------------------------------
// tb_cpu_writeback
//
// Self-checking bench for cpu_writeback: reset checks, hand-written
// multi-cycle sequences, a table of decode-hazard vectors, and a randomized
// run compared against a queue-based reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_cpu_writeback;

    localparam int FIFO_DEPTH   = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clock;
    logic        reset;
    logic [4:0]  p4_dest_reg;
    logic [31:0] p4_result;
    logic        lu_issue;
    logic [4:0]  lu_issue_reg;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_dest_reg;
    logic [31:0] lu_result;
    logic [4:0]  p2_reg_a;
    logic [4:0]  p2_reg_b;
    logic        p2_literal_b;
    logic [4:0]  p2_dest_reg;
    logic        p2_hazard;
    logic        wb_stall;
    logic [4:0]  p5_dest_reg;
    logic [31:0] p5_result;

    int n_checks = 0;
    int n_errors = 0;

    cpu_writeback #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .p4_dest_reg  (p4_dest_reg),
        .p4_result    (p4_result),
        .lu_issue     (lu_issue),
        .lu_issue_reg (lu_issue_reg),
        .lu_valid     (lu_valid),
        .lu_ready     (lu_ready),
        .lu_dest_reg  (lu_dest_reg),
        .lu_result    (lu_result),
        .p2_reg_a     (p2_reg_a),
        .p2_reg_b     (p2_reg_b),
        .p2_literal_b (p2_literal_b),
        .p2_dest_reg  (p2_dest_reg),
        .p2_hazard    (p2_hazard),
        .wb_stall     (wb_stall),
        .p5_dest_reg  (p5_dest_reg),
        .p5_result    (p5_result)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        p4_dest_reg  = 5'd0;
        p4_result    = 32'd0;
        lu_issue     = 1'b0;
        lu_issue_reg = 5'd0;
        lu_valid     = 1'b0;
        lu_dest_reg  = 5'd0;
        lu_result    = 32'd0;
        p2_reg_a     = 5'd0;
        p2_reg_b     = 5'd0;
        p2_literal_b = 1'b0;
        p2_dest_reg  = 5'd0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic to_sample();
        @(negedge clock);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- hazard vector table ----------------
    typedef struct packed {
        logic [4:0] a;
        logic [4:0] b;
        logic       lit;
        logic [4:0] dest;
        logic       issue;
        logic [4:0] issue_reg;
        logic       exp_hazard;
    } vec_t;

    vec_t vecs[13];

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] data;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pend;
    logic [4:0]  m_p5_dest;
    logic [31:0] m_p5_data;
    logic        m_p5_lu;
    logic        m_stall;
    int          m_starve;

    task automatic model_reset();
        m_q.delete();
        m_pend    = 32'd0;
        m_p5_dest = 5'd0;
        m_p5_data = 32'd0;
        m_p5_lu   = 1'b0;
        m_stall   = 1'b0;
        m_starve  = 0;
    endtask

    function automatic logic m_hazard();
        logic use_b;
        logic h;
        use_b = !p2_literal_b;
        h = m_pend[p2_reg_a] || (use_b && m_pend[p2_reg_b]) || m_pend[p2_dest_reg];
        if (lu_issue && lu_issue_reg != 5'd0) begin
            if (lu_issue_reg == p2_reg_a || (use_b && lu_issue_reg == p2_reg_b) ||
                lu_issue_reg == p2_dest_reg) begin
                h = 1'b1;
            end
        end
        return h;
    endfunction

    // Advance the model by one clock using the inputs of the current cycle.
    task automatic model_step();
        int   size_before;
        logic blocked;
        ent_t e;
        if (reset) begin
            model_reset();
            return;
        end
        size_before = m_q.size();
        blocked = (p4_dest_reg != 5'd0) && (size_before > 0);
        if (m_p5_lu && m_p5_dest != 5'd0) m_pend[m_p5_dest] = 1'b0;
        if (lu_issue && lu_issue_reg != 5'd0) m_pend[lu_issue_reg] = 1'b1;
        if (lu_valid && size_before < FIFO_DEPTH && lu_dest_reg != 5'd0) begin
            e.dest = lu_dest_reg;
            e.data = lu_result;
            m_q.push_back(e);
        end
        if (p4_dest_reg != 5'd0) begin
            m_p5_dest = p4_dest_reg;
            m_p5_data = p4_result;
            m_p5_lu   = 1'b0;
        end else if (m_q.size() != 0) begin
            e = m_q.pop_front();
            m_p5_dest = e.dest;
            m_p5_data = e.data;
            m_p5_lu   = 1'b1;
        end else begin
            m_p5_dest = 5'd0;
            m_p5_data = 32'd0;
            m_p5_lu   = 1'b0;
        end
        m_stall  = blocked && (m_starve + 1 == STARVE_LIMIT);
        m_starve = blocked ? m_starve + 1 : 0;
    endtask

    task automatic model_check();
        chk("rnd_p5_dest", 32'(p5_dest_reg), 32'(m_p5_dest));
        if (m_p5_dest != 5'd0) chk("rnd_p5_result", p5_result, m_p5_data);
        chk("rnd_lu_ready", 32'(lu_ready), 32'(m_q.size() < FIFO_DEPTH));
        chk("rnd_wb_stall", 32'(wb_stall), 32'(m_stall));
        chk("rnd_p2_hazard", 32'(p2_hazard), 32'(m_hazard()));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        //           a   b  lit dest iss ireg exp   (pending: 7, 9, 12)
        vecs[0]  = '{5'd1,  5'd2,  1'b0, 5'd3,  1'b0, 5'd0,  1'b0};
        vecs[1]  = '{5'd7,  5'd2,  1'b0, 5'd3,  1'b0, 5'd0,  1'b1};
        vecs[2]  = '{5'd1,  5'd9,  1'b0, 5'd3,  1'b0, 5'd0,  1'b1};
        vecs[3]  = '{5'd1,  5'd9,  1'b1, 5'd3,  1'b0, 5'd0,  1'b0};
        vecs[4]  = '{5'd1,  5'd2,  1'b1, 5'd12, 1'b0, 5'd0,  1'b1};
        vecs[5]  = '{5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0};
        vecs[6]  = '{5'd15, 5'd2,  1'b0, 5'd3,  1'b1, 5'd15, 1'b1};
        vecs[7]  = '{5'd1,  5'd15, 1'b1, 5'd3,  1'b1, 5'd15, 1'b0};
        vecs[8]  = '{5'd1,  5'd15, 1'b0, 5'd3,  1'b1, 5'd15, 1'b1};
        vecs[9]  = '{5'd1,  5'd2,  1'b0, 5'd15, 1'b1, 5'd15, 1'b1};
        vecs[10] = '{5'd0,  5'd0,  1'b0, 5'd0,  1'b1, 5'd0,  1'b0};
        vecs[11] = '{5'd1,  5'd2,  1'b0, 5'd3,  1'b1, 5'd16, 1'b0};
        vecs[12] = '{5'd8,  5'd10, 1'b0, 5'd11, 1'b0, 5'd0,  1'b0};

        idle_inputs();
        reset = 1'b1;
        repeat (3) next_cycle();
        reset = 1'b0;

        // Reset / idle state
        to_sample();
        chk("rst_p5_dest", 32'(p5_dest_reg), 32'd0);
        chk("rst_p5_result", p5_result, 32'd0);
        chk("rst_lu_ready", 32'(lu_ready), 32'd1);
        chk("rst_wb_stall", 32'(wb_stall), 32'd0);
        for (int r = 0; r < 32; r += 5) begin
            p2_reg_a = 5'(r); p2_reg_b = 5'(31 - r); p2_dest_reg = 5'(r + 1);
            #1;
            chk("rst_p2_hazard", 32'(p2_hazard), 32'd0);
        end

        // Long op on r5, result 3 cycles later, hazard lifetime
        next_cycle();
        idle_inputs();
        lu_issue = 1'b1; lu_issue_reg = 5'd5; p2_reg_a = 5'd5;
        to_sample();
        chk("t2_issue_hazard", 32'(p2_hazard), 32'd1);
        next_cycle();
        lu_issue = 1'b0;
        to_sample();
        chk("t2_pend_hazard_1", 32'(p2_hazard), 32'd1);
        next_cycle();
        to_sample();
        chk("t2_pend_hazard_2", 32'(p2_hazard), 32'd1);
        next_cycle();
        lu_valid = 1'b1; lu_dest_reg = 5'd5; lu_result = 32'h1234;
        to_sample();
        chk("t2_lu_ready", 32'(lu_ready), 32'd1);
        chk("t2_push_hazard", 32'(p2_hazard), 32'd1);
        next_cycle();
        lu_valid = 1'b0;
        to_sample();
        chk("t2_p5_dest", 32'(p5_dest_reg), 32'd5);
        chk("t2_p5_result", p5_result, 32'h1234);
        chk("t2_write_hazard", 32'(p2_hazard), 32'd1);
        next_cycle();
        to_sample();
        chk("t2_cleared_hazard", 32'(p2_hazard), 32'd0);
        chk("t2_p5_idle", 32'(p5_dest_reg), 32'd0);

        // Table-driven decode hazard vectors with r7, r9, r12 pending
        idle_inputs();
        foreach (vecs[i]) begin end
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            lu_issue = 1'b1;
            lu_issue_reg = (k == 0) ? 5'd7 : (k == 1) ? 5'd9 : 5'd12;
        end
        next_cycle();
        lu_issue = 1'b0;
        for (int i = 0; i < 13; i++) begin
            next_cycle();
            p2_reg_a     = vecs[i].a;
            p2_reg_b     = vecs[i].b;
            p2_literal_b = vecs[i].lit;
            p2_dest_reg  = vecs[i].dest;
            lu_issue     = vecs[i].issue;
            lu_issue_reg = vecs[i].issue_reg;
            #3;
            chk($sformatf("vec%0d_hazard", i), 32'(p2_hazard), 32'(vecs[i].exp_hazard));
            // Drop the issue before the edge so the pending set stays fixed
            lu_issue = 1'b0;
        end

        // Reset with FIFO full and three pending bits
        next_cycle();
        idle_inputs();
        p4_dest_reg = 5'd1; p4_result = 32'h11;
        lu_issue = 1'b1; lu_issue_reg = 5'd20;
        next_cycle();
        lu_issue_reg = 5'd21;
        lu_valid = 1'b1; lu_dest_reg = 5'd20; lu_result = 32'hD0;
        next_cycle();
        lu_issue_reg = 5'd22;
        lu_dest_reg = 5'd21; lu_result = 32'hD1;
        next_cycle();
        lu_issue = 1'b0; lu_valid = 1'b0;
        p2_reg_a = 5'd20;
        reset = 1'b1;
        to_sample();
        chk("t6_full_lu_ready", 32'(lu_ready), 32'd0);
        chk("t6_pre_hazard", 32'(p2_hazard), 32'd1);
        next_cycle();
        reset = 1'b0;
        idle_inputs();
        p2_reg_a = 5'd20; p2_reg_b = 5'd21; p2_dest_reg = 5'd22;
        to_sample();
        chk("t6_lu_ready", 32'(lu_ready), 32'd1);
        chk("t6_p5_dest", 32'(p5_dest_reg), 32'd0);
        chk("t6_wb_stall", 32'(wb_stall), 32'd0);
        chk("t6_hazard", 32'(p2_hazard), 32'd0);
        next_cycle();
        p2_reg_a = 5'd7; p2_reg_b = 5'd9; p2_dest_reg = 5'd12;
        to_sample();
        chk("t6_no_pop", 32'(p5_dest_reg), 32'd0);
        chk("t6_old_pend", 32'(p2_hazard), 32'd0);

        // Starvation: one buffered result behind continuous pipeline writes
        next_cycle();
        idle_inputs();
        p4_dest_reg = 5'd1; p4_result = 32'h100;
        lu_valid = 1'b1; lu_dest_reg = 5'd6; lu_result = 32'hA5A5_0006;
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            lu_valid = 1'b0;
            p4_dest_reg = 5'(k + 1); p4_result = 32'h100 + 32'(k);
            to_sample();
            chk($sformatf("t3_no_stall_%0d", k), 32'(wb_stall), 32'd0);
            chk($sformatf("t3_p5_pipe_%0d", k), 32'(p5_dest_reg), 32'(k));
        end
        next_cycle();
        p4_dest_reg = 5'd0; p4_result = 32'd0;
        to_sample();
        chk("t3_stall", 32'(wb_stall), 32'd1);
        next_cycle();
        to_sample();
        chk("t3_stall_drop", 32'(wb_stall), 32'd0);
        chk("t3_pop_dest", 32'(p5_dest_reg), 32'd6);
        chk("t3_pop_result", p5_result, 32'hA5A5_0006);

        // Fill the buffer, hold a third result, check ordering
        next_cycle();
        idle_inputs();
        p4_dest_reg = 5'd2; p4_result = 32'h200;
        lu_valid = 1'b1; lu_dest_reg = 5'd10; lu_result = 32'hC10;
        next_cycle();
        lu_dest_reg = 5'd11; lu_result = 32'hC11;
        next_cycle();
        lu_dest_reg = 5'd12; lu_result = 32'hC12;
        to_sample();
        chk("t4_full", 32'(lu_ready), 32'd0);
        next_cycle();
        p4_dest_reg = 5'd0; p4_result = 32'd0;
        to_sample();
        chk("t4_still_full", 32'(lu_ready), 32'd0);
        next_cycle();
        to_sample();
        chk("t4_ready_again", 32'(lu_ready), 32'd1);
        chk("t4_first_dest", 32'(p5_dest_reg), 32'd10);
        chk("t4_first_result", p5_result, 32'hC10);
        next_cycle();
        lu_valid = 1'b0;
        to_sample();
        chk("t4_second_dest", 32'(p5_dest_reg), 32'd11);
        chk("t4_second_result", p5_result, 32'hC11);
        next_cycle();
        to_sample();
        chk("t4_third_dest", 32'(p5_dest_reg), 32'd12);
        chk("t4_third_result", p5_result, 32'hC12);
        next_cycle();
        to_sample();
        chk("t4_drained", 32'(p5_dest_reg), 32'd0);
        chk("t4_no_stall", 32'(wb_stall), 32'd0);

        // Randomized run against the reference model
        next_cycle();
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            reset        = ($urandom_range(0, 499) == 0);
            p4_dest_reg  = (wb_stall || $urandom_range(0, 9) < 4) ? 5'd0
                                                                 : 5'($urandom_range(1, 31));
            p4_result    = $urandom;
            lu_issue     = ($urandom_range(0, 3) == 0);
            lu_issue_reg = 5'($urandom_range(0, 7));
            lu_valid     = ($urandom_range(0, 2) == 0);
            lu_dest_reg  = 5'($urandom_range(0, 7));
            lu_result    = $urandom;
            p2_reg_a     = 5'($urandom_range(0, 9));
            p2_reg_b     = 5'($urandom_range(0, 9));
            p2_literal_b = 1'($urandom_range(0, 1));
            p2_dest_reg  = 5'($urandom_range(0, 9));
            to_sample();
            model_check();
            model_step();
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
